// File: rtl/azimuth_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// azimuth_ctrl_pkg : sequencer state encoding and pattern-size helpers
// Revision: 1.0
// ============================================================================
package azimuth_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_HOLD      = 3'd2,
    ST_SWAP      = 3'd3,
    ST_PRE_EN    = 3'd4,
    ST_TRIG      = 3'd5,
    ST_RUN       = 3'd6
  } ctrl_state_e;

  localparam int unsigned CNT_W = 16;

  function automatic int calc_nwords(input int size, input int word_w);
    return (size + word_w - 1) / word_w;
  endfunction

  function automatic int calc_aw(input int nwords);
    return (nwords <= 1) ? 1 : $clog2(nwords);
  endfunction

endpackage
`default_nettype wire

// File: rtl/azimuth_pattern_buffer.sv
`default_nettype none
// ============================================================================
// azimuth_pattern_buffer : word-writable shadow pattern plus swapped-in active copy
// Revision: 1.0
// ============================================================================
module azimuth_pattern_buffer
  import azimuth_ctrl_pkg::*;
#(
  parameter  int SIZE   = 3200,
  parameter  int WORD_W = 32,
  localparam int NWORDS = calc_nwords(SIZE, WORD_W),
  localparam int AW     = calc_aw(NWORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              swap_i,
  output logic              addr_err_o,
  output logic              valid_o,
  output logic [SIZE-1:0]   active_o
);

  localparam logic [AW:0] NWORDS_L = (AW+1)'(NWORDS);

  logic [SIZE-1:0] shadow;
  logic [SIZE-1:0] active_q;
  logic            valid_q;

  assign addr_err_o = wr_en_i && ({1'b0, wr_addr_i} >= NWORDS_L);

  // The last word may be narrower than WORD_W; its excess input bits are dropped.
  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    localparam int LSB = k * WORD_W;
    localparam int WW  = ((SIZE - LSB) < WORD_W) ? (SIZE - LSB) : WORD_W;

    logic [WW-1:0] word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        word_q <= '0;
      end else if (wr_en_i && (wr_addr_i == AW'(k))) begin
        word_q <= wr_data_i[WW-1:0];
      end
    end

    assign shadow[LSB +: WW] = word_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= '0;
      valid_q  <= 1'b0;
    end else if (swap_i) begin
      active_q <= shadow;
      valid_q  <= 1'b1;
    end
  end

  assign active_o = active_q;
  assign valid_o  = valid_q;

endmodule
`default_nettype wire

// File: rtl/azimuth_generator_ctrl.sv
`default_nettype none
// ============================================================================
// azimuth_generator_ctrl : ARP-aligned EN/TRIG sequencer and pattern swap control
// Revision: 1.0
// ============================================================================
module azimuth_generator_ctrl
  import azimuth_ctrl_pkg::*;
#(
  parameter  int SIZE     = 3200,
  parameter  int WORD_W   = 32,
  parameter  int HOLD_CYC = 2,
  parameter  int TRIG_LEN = 1,
  localparam int NWORDS   = calc_nwords(SIZE, WORD_W),
  localparam int AW       = calc_aw(NWORDS)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              WR_EN,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [WORD_W-1:0] WR_DATA,
  input  logic              COMMIT,
  input  logic              ARM,
  input  logic              STOP,
  input  logic              ARP,
  input  logic              ERR_CLR,
  output logic              GEN_EN,
  output logic              GEN_TRIG,
  output logic [SIZE-1:0]   GEN_DATA,
  output logic              PENDING,
  output logic              RUNNING,
  output logic              ERR_OVERRUN,
  output logic              ERR_ADDR
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_LEN - 1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             gen_en_q, gen_trig_q, running_q;
  logic             err_overrun_q, err_overrun_d;
  logic             err_addr_q, err_addr_d;

  logic             active_valid;
  logic             addr_err;
  logic             busy;
  logic             commit_load;
  logic             swap;

  azimuth_pattern_buffer #(
    .SIZE   (SIZE),
    .WORD_W (WORD_W)
  ) u_buf (
    .clk_i      (CLK),
    .rst_ni     (RSTN),
    .wr_en_i    (WR_EN),
    .wr_addr_i  (WR_ADDR),
    .wr_data_i  (WR_DATA),
    .swap_i     (swap),
    .addr_err_o (addr_err),
    .valid_o    (active_valid),
    .active_o   (GEN_DATA)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:      if (ARM && active_valid) state_d = ST_WAIT_SYNC;
      ST_WAIT_SYNC: if (ARP) state_d = ST_PRE_EN;
      ST_PRE_EN: begin
        state_d = ST_TRIG;
        cnt_d   = '0;
      end
      ST_TRIG: begin
        if (cnt_q == TRIG_LAST) state_d = ST_RUN;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (ARP) begin
          cnt_d   = '0;
          state_d = pending_q ? ST_HOLD : ST_TRIG;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_SWAP;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_SWAP:      state_d = ST_PRE_EN;
      default:      state_d = ST_IDLE;
    endcase
    if (STOP) state_d = ST_IDLE;
  end

  // Outside of generation a commit loads the active pattern straight away.
  assign commit_load = COMMIT && ((state_q == ST_IDLE) || (state_q == ST_WAIT_SYNC));
  assign swap        = commit_load || (state_d == ST_SWAP);
  assign busy        = (state_q == ST_HOLD) || (state_q == ST_SWAP) ||
                       (state_q == ST_PRE_EN) || (state_q == ST_TRIG);

  always_comb begin
    pending_d = pending_q;
    if (commit_load)             pending_d = 1'b0;
    else if (COMMIT)             pending_d = 1'b1;
    else if (state_d == ST_SWAP) pending_d = 1'b0;

    err_overrun_d = (err_overrun_q && !ERR_CLR) || (ARP && busy);
    err_addr_d    = (err_addr_q && !ERR_CLR) || addr_err;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      gen_en_q      <= 1'b0;
      gen_trig_q    <= 1'b0;
      running_q     <= 1'b0;
      err_overrun_q <= 1'b0;
      err_addr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      gen_en_q      <= (state_d == ST_PRE_EN) || (state_d == ST_TRIG) || (state_d == ST_RUN);
      gen_trig_q    <= (state_d == ST_TRIG);
      running_q     <= (state_d == ST_RUN);
      err_overrun_q <= err_overrun_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign GEN_EN      = gen_en_q;
  assign GEN_TRIG    = gen_trig_q;
  assign PENDING     = pending_q;
  assign RUNNING     = running_q;
  assign ERR_OVERRUN = err_overrun_q;
  assign ERR_ADDR    = err_addr_q;

endmodule
`default_nettype wire
